// File: rtl/s_pl_hs_nclk.sv
// DELAY-stage valid/ready register pipeline with bubble collapsing, synchronous
// flush and an occupancy count; DELAY=0 degenerates to a combinational wire.
module s_pl_hs_nclk #(
    parameter int              SIZE    = 8,
    parameter int              DELAY   = 3,
    parameter logic [SIZE-1:0] RST_VAL = {SIZE{1'b0}},
    parameter int              CNTW    = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            ivld,
    output logic            irdy,
    input  logic [SIZE-1:0] idat,
    output logic            ovld,
    input  logic            ordy,
    output logic [SIZE-1:0] odat,
    output logic [CNTW-1:0] occ
);

    generate
        if (DELAY == 0) begin : g_pass
            // No state at all, so the clock and both clears are intentionally unused.
            logic w_unused;
            assign w_unused = ^{clk, rst, flush};

            assign ovld = ivld;
            assign irdy = ordy;
            assign odat = idat;
            assign occ  = '0;
        end else begin : g_pipe
            logic             w_acc;
            logic [DELAY-1:0] w_vld_vec;
            logic [CNTW-1:0]  w_occ;

            assign w_acc = ivld & irdy;

            for (genvar gi = 0; gi < DELAY; gi++) begin : g_stage
                logic            r_vld;
                logic [SIZE-1:0] r_dat;
                logic            w_en;
                logic            w_in_vld;
                logic [SIZE-1:0] w_in_dat;

                if (gi == 0) begin : g_head
                    assign w_in_vld = w_acc;
                    assign w_in_dat = idat;
                end else begin : g_body
                    assign w_in_vld = g_stage[gi-1].r_vld;
                    assign w_in_dat = g_stage[gi-1].r_dat;
                end

                // An empty stage always advances, letting bubbles collapse under a stall.
                if (gi == DELAY - 1) begin : g_tail_en
                    assign w_en = ~r_vld | ordy;
                end else begin : g_mid_en
                    assign w_en = ~r_vld | g_stage[gi+1].w_en;
                end

                always_ff @(posedge clk) begin
                    if (rst || flush) begin
                        r_vld <= 1'b0;
                        r_dat <= RST_VAL;
                    end else if (w_en) begin
                        r_vld <= w_in_vld;
                        // Bubbles leave the data register untouched.
                        if (w_in_vld) begin
                            r_dat <= w_in_dat;
                        end
                    end
                end

                assign w_vld_vec[gi] = r_vld;
            end

            always_comb begin
                w_occ = '0;
                for (int i = 0; i < DELAY; i++) begin
                    w_occ = w_occ + CNTW'(w_vld_vec[i]);
                end
            end

            assign irdy = g_stage[0].w_en & ~flush & ~rst;
            assign ovld = g_stage[DELAY-1].r_vld;
            assign odat = g_stage[DELAY-1].r_dat;
            assign occ  = w_occ;
        end
    endgenerate

endmodule

// File: tb/tb_s_pl_hs_nclk.sv
// Directed bench: a DELAY=3 instance for streaming, stall, bubble, flush and reset
// behaviour, plus a DELAY=0 instance checked as a pass-through.
module tb_s_pl_hs_nclk;

    localparam logic [7:0] RV = 8'hC3;

    logic       clk = 1'b0;
    logic       rst, flush, ivld, ordy;
    logic [7:0] idat;
    logic       irdy, ovld;
    logic [7:0] odat;
    logic [1:0] occ;

    logic       z_flush, z_ivld, z_ordy, z_irdy, z_ovld;
    logic [3:0] z_idat, z_odat;
    logic       z_occ;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] next_in, exp_out;
    logic       irdy_s;

    always #5 clk = ~clk;

    s_pl_hs_nclk #(.SIZE(8), .DELAY(3), .RST_VAL(RV), .CNTW(2)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .ivld(ivld), .irdy(irdy), .idat(idat),
        .ovld(ovld), .ordy(ordy), .odat(odat), .occ(occ)
    );

    s_pl_hs_nclk #(.SIZE(4), .DELAY(0), .RST_VAL(4'h0), .CNTW(1)) u_d0 (
        .clk(clk), .rst(rst), .flush(z_flush), .ivld(z_ivld), .irdy(z_irdy), .idat(z_idat),
        .ovld(z_ovld), .ordy(z_ordy), .odat(z_odat), .occ(z_occ)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One clock cycle: drive, sample pre-edge handshakes, check output order, clock.
    task automatic step(input logic v, input logic r);
        ivld = v;
        idat = next_in;
        ordy = r;
        #1;
        irdy_s = irdy;
        if (ovld && ordy) begin
            $display("t=%0t out %02h (expect %02h)", $time, odat, exp_out);
            chk("order", 32'(odat), 32'(exp_out));
            exp_out = exp_out + 8'd1;
        end
        if (ivld && irdy) begin
            $display("t=%0t in  %02h", $time, idat);
            next_in = next_in + 8'd1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; ivld = 1'b0; ordy = 1'b0; idat = 8'h00;
        z_flush = 1'b0; z_ivld = 1'b0; z_ordy = 1'b0; z_idat = 4'h0;
        next_in = 8'h00; exp_out = 8'h00;

        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_irdy", 32'(irdy), 0);
        chk("rst_ovld", 32'(ovld), 0);
        chk("rst_occ",  32'(occ), 0);
        chk("rst_odat", 32'(odat), 32'(RV));
        rst = 1'b0;
        #1;
        chk("post_rst_irdy", 32'(irdy), 1);

        // Streaming 0x01..0x10 with ordy held high
        next_in = 8'h01; exp_out = 8'h01;
        for (int c = 0; c <= 18; c++) begin
            step(c < 16, 1'b1);
            if (c < 16) chk("stream_irdy", 32'(irdy_s), 1);
            chk("stream_ovld", 32'(ovld), 32'((c >= 2 && c <= 17) ? 1 : 0));
            if (c >= 2 && c <= 15) chk("stream_occ", 32'(occ), 3);
        end
        chk("stream_all_out", 32'(exp_out), 32'h11);
        chk("stream_drained", 32'(occ), 0);

        // Six-cycle downstream stall mid-stream
        next_in = 8'h20; exp_out = 8'h20;
        for (int c = 0; c <= 15; c++) begin
            step(next_in < 8'h28, !(c >= 1 && c <= 6));
            if (c <= 7) chk("stall_irdy", 32'(irdy_s), 32'((c <= 2 || c == 7) ? 1 : 0));
            if (c <= 6) chk("stall_occ", 32'(occ), 32'((c == 0) ? 1 : (c == 1) ? 2 : 3));
        end
        chk("stall_all_out", 32'(exp_out), 32'h28);
        chk("stall_drained", 32'(occ), 0);

        // Single word travels to the last stage, then bubbles collapse behind it
        next_in = 8'hA5; exp_out = 8'hA5;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("single_ovld", 32'(ovld), 1);
        chk("single_odat", 32'(odat), 32'hA5);
        chk("single_occ",  32'(occ), 1);
        step(1'b1, 1'b0);
        chk("fill_occ2", 32'(occ), 2);
        step(1'b1, 1'b0);
        chk("fill_occ3", 32'(occ), 3);
        chk("fill_odat", 32'(odat), 32'hA5);
        step(1'b1, 1'b0);
        chk("full_irdy", 32'(irdy_s), 0);
        chk("full_hold_occ", 32'(occ), 3);

        // Full pipeline, simultaneous in and out
        step(1'b1, 1'b1);
        chk("swap_irdy", 32'(irdy_s), 1);
        chk("swap_occ",  32'(occ), 3);
        chk("swap_odat", 32'(odat), 32'hA6);

        // Flush with ivld high; the output word in that cycle still delivers
        flush = 1'b1;
        step(1'b1, 1'b1);
        flush = 1'b0;
        chk("flush_irdy", 32'(irdy_s), 0);
        chk("flush_occ",  32'(occ), 0);
        chk("flush_ovld", 32'(ovld), 0);
        chk("flush_odat", 32'(odat), 32'(RV));
        chk("flush_delivered", 32'(exp_out), 32'hA7);

        // Refill, then reset mid-stream
        next_in = 8'hB0; exp_out = 8'hB0;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("refill_occ", 32'(occ), 3);
        rst = 1'b1;
        step(1'b1, 1'b0);
        rst = 1'b0;
        chk("rst2_irdy", 32'(irdy_s), 0);
        chk("rst2_occ",  32'(occ), 0);
        chk("rst2_ovld", 32'(ovld), 0);
        chk("rst2_odat", 32'(odat), 32'(RV));
        #1;
        chk("rst2_after_irdy", 32'(irdy), 1);

        // DELAY=0 pass-through with random handshakes
        for (int i = 0; i < 20; i++) begin
            z_ivld  = 1'($urandom_range(0, 1));
            z_ordy  = 1'($urandom_range(0, 1));
            z_flush = 1'($urandom_range(0, 1));
            z_idat  = 4'($urandom_range(0, 15));
            #1;
            chk("d0_ovld", 32'(z_ovld), 32'(z_ivld));
            chk("d0_irdy", 32'(z_irdy), 32'(z_ordy));
            chk("d0_odat", 32'(z_odat), 32'(z_idat));
            chk("d0_occ",  32'(z_occ), 0);
            #4;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
